// File: rtl/dino_game_ctrl.sv
// Dino runner sequencer: game/jump FSMs, obstacle scroll and wrap, collision, score, speed ramp.
// Define DINO_AUTOJUMP_EN to add a demo autopilot that requests jumps just ahead of the obstacle.
module dino_game_ctrl #(
  parameter int TICK_DIV    = 500_000,
  parameter int GROUND_Y    = 450,
  parameter int JUMP_V0     = 12,
  parameter int GRAVITY     = 1,
  parameter int BLK_START_X = 750,
  parameter int BLK_END_X   = 50,
  parameter int BLK_STEP    = 2,
  parameter int HIT_XL      = 175,
  parameter int HIT_XR      = 325,
  parameter int HIT_Y       = 400,
  parameter int SPD_INIT    = 200_000,
  parameter int SPD_STEP    = 10_000,
  parameter int SPD_MIN     = 50_000,
  parameter int RAMP_EVERY  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_jump,
  input  logic        btn_start,
  output logic [9:0]  dino_y,
  output logic [9:0]  blk_x,
  output logic [21:0] spd,
  output logic        isover,
  output logic [15:0] score
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RW = $clog2(RAMP_EVERY + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [9:0]    GY        = 10'(GROUND_Y);
  localparam logic [9:0]    BSX       = 10'(BLK_START_X);
  localparam logic [9:0]    BWRAP     = 10'(BLK_END_X + BLK_STEP);
  localparam logic [9:0]    BSTEP     = 10'(BLK_STEP);
  localparam logic [9:0]    HXL       = 10'(HIT_XL);
  localparam logic [9:0]    HXR       = 10'(HIT_XR);
  localparam logic [9:0]    HY        = 10'(HIT_Y);
  localparam logic [5:0]    V0        = 6'(JUMP_V0);
  localparam logic [5:0]    GRAV      = 6'(GRAVITY);
  localparam logic [21:0]   SPD0      = 22'(SPD_INIT);
  localparam logic [21:0]   SMIN      = 22'(SPD_MIN);
  localparam logic [22:0]   SSTEP     = 23'(SPD_STEP);
  localparam logic [RW-1:0] RAMP_N    = RW'(RAMP_EVERY);

  typedef enum logic [1:0] {IDLE, RUN, OVER} game_t;
  typedef enum logic [1:0] {GROUND, RISE, FALL} jump_t;

  game_t          game, game_n;
  jump_t          jump, jump_n;
  logic [5:0]     vel, vel_n;
  logic [RW-1:0]  ramp_cnt, ramp_n, ramp_inc;
  logic           jump_req, req_n;
  logic [TW-1:0]  tick_cnt;
  logic           tick;
  logic [2:0]     jsync, ssync;
  logic           jp, sp;
  logic           auto_jump;
  logic [9:0]     y_n, bx_n;
  logic [21:0]    spd_n;
  logic [15:0]    score_n;
  logic           over_n;
  logic [10:0]    fall_sum;
  logic [22:0]    spd_dec;
  logic           wrap, hit;

  // Bit 0/1 form the synchroniser; bit 2 is the previous synchronised level for edge detect.
  assign jp   = jsync[1] & ~jsync[2];
  assign sp   = ssync[1] & ~ssync[2];
  assign tick = (tick_cnt == TICK_LAST);

`ifdef DINO_AUTOJUMP_EN
  localparam logic [9:0] HXR_AHEAD = 10'(HIT_XR + 40);
  assign auto_jump = (game == RUN) && (jump == GROUND) && (blk_x <= HXR_AHEAD) && (blk_x > HXR);
`else
  assign auto_jump = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      game     <= IDLE;
      jump     <= GROUND;
      vel      <= '0;
      ramp_cnt <= '0;
      jump_req <= 1'b0;
      tick_cnt <= '0;
      jsync    <= '0;
      ssync    <= '0;
      dino_y   <= GY;
      blk_x    <= BSX;
      spd      <= SPD0;
      isover   <= 1'b0;
      score    <= '0;
    end else begin
      jsync    <= {jsync[1:0], btn_jump};
      ssync    <= {ssync[1:0], btn_start};
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      game     <= game_n;
      jump     <= jump_n;
      vel      <= vel_n;
      ramp_cnt <= ramp_n;
      jump_req <= req_n;
      dino_y   <= y_n;
      blk_x    <= bx_n;
      spd      <= spd_n;
      isover   <= over_n;
      score    <= score_n;
    end
  end

  always_comb begin
    game_n   = game;
    jump_n   = jump;
    vel_n    = vel;
    ramp_n   = ramp_cnt;
    req_n    = jump_req;
    y_n      = dino_y;
    bx_n     = blk_x;
    spd_n    = spd;
    over_n   = isover;
    score_n  = score;
    fall_sum = '0;
    spd_dec  = '0;
    ramp_inc = ramp_cnt + RW'(1);
    wrap     = 1'b0;
    hit      = 1'b0;
    case (game)
      IDLE, OVER: begin
        if (sp) begin
          game_n  = RUN;
          jump_n  = GROUND;
          vel_n   = '0;
          ramp_n  = '0;
          req_n   = 1'b0;
          y_n     = GY;
          bx_n    = BSX;
          spd_n   = SPD0;
          over_n  = 1'b0;
          score_n = '0;
        end
      end
      RUN: begin
        if (jp || auto_jump) req_n = 1'b1;
        if (tick) begin
          req_n = 1'b0;
          case (jump)
            GROUND: begin
              if (jump_req || jp || auto_jump) begin
                jump_n = RISE;
                vel_n  = V0;
              end
            end
            RISE: begin
              y_n   = dino_y - 10'(vel);
              vel_n = vel - GRAV;
              if (vel_n == '0) jump_n = FALL;
            end
            FALL: begin
              vel_n    = vel + GRAV;
              fall_sum = {1'b0, dino_y} + 11'(vel_n);
              if (fall_sum >= {1'b0, GY}) begin
                y_n    = GY;
                vel_n  = '0;
                jump_n = GROUND;
              end else begin
                y_n = fall_sum[9:0];
              end
            end
            default: jump_n = GROUND;
          endcase

          if (blk_x <= BWRAP) begin
            bx_n = BSX;
            wrap = 1'b1;
          end else begin
            bx_n = blk_x - BSTEP;
          end

          // Collision is judged on the freshly updated positions and takes priority over scoring.
          hit = (bx_n > HXL) && (bx_n < HXR) && (y_n > HY);
          if (hit) begin
            game_n = OVER;
            over_n = 1'b1;
          end else if (wrap) begin
            if (score != 16'hFFFF) score_n = score + 16'd1;
            if (ramp_inc == RAMP_N) begin
              ramp_n  = '0;
              spd_dec = {1'b0, spd} - SSTEP;
              if (spd_dec[22] || (spd_dec < {1'b0, SMIN})) spd_n = SMIN;
              else                                          spd_n = spd_dec[21:0];
            end else begin
              ramp_n = ramp_inc;
            end
          end
        end
      end
      default: game_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dino_game_ctrl.sv
// Bench for dino_game_ctrl: three parameterisations driven by shared buttons, checked every tick
// against a per-instance reference model, plus directed checks of the documented scenarios.
module tb_dino_game_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_jump = 1'b0;
  logic btn_start = 1'b0;

  logic [9:0]  dy [3];
  logic [9:0]  bx [3];
  logic [21:0] sv [3];
  logic        ov [3];
  logic [15:0] sc [3];

  int n_cmp = 0;
  int n_bad = 0;
  int step_no = 0;

  // d0: stock geometry; d1: short track that never collides; d2: collision only on the wrap value.
  int sx  [3] = '{750, 60, 60};
  int hxl [3] = '{175, 175, 58};
  int hxr [3] = '{325, 325, 100};
  int hy  [3] = '{400, 1000, 400};

  typedef struct {
    bit running;
    bit over;
    int air;
    int y;
    int x;
    int spd;
    int score;
    int vel;
    int ramp;
  } mdl_t;
  mdl_t m [3];

  always #5 clk = ~clk;

  dino_game_ctrl #(.TICK_DIV(4)) d0 (
    .clk(clk), .rst(rst), .btn_jump(btn_jump), .btn_start(btn_start),
    .dino_y(dy[0]), .blk_x(bx[0]), .spd(sv[0]), .isover(ov[0]), .score(sc[0]));
  dino_game_ctrl #(.TICK_DIV(4), .BLK_START_X(60), .HIT_Y(1000)) d1 (
    .clk(clk), .rst(rst), .btn_jump(btn_jump), .btn_start(btn_start),
    .dino_y(dy[1]), .blk_x(bx[1]), .spd(sv[1]), .isover(ov[1]), .score(sc[1]));
  dino_game_ctrl #(.TICK_DIV(4), .BLK_START_X(60), .HIT_XL(58), .HIT_XR(100)) d2 (
    .clk(clk), .rst(rst), .btn_jump(btn_jump), .btn_start(btn_start),
    .dino_y(dy[2]), .blk_x(bx[2]), .spd(sv[2]), .isover(ov[2]), .score(sc[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s step=%0d observed=%0d expected=%0d", tag, step_no, obs, exp);
    end
  endtask

  task automatic model_reload(input int i);
    m[i].over  = 1'b0;
    m[i].air   = 0;
    m[i].y     = 450;
    m[i].x     = sx[i];
    m[i].spd   = 200000;
    m[i].score = 0;
    m[i].vel   = 0;
    m[i].ramp  = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      model_reload(i);
      m[i].running = 1'b0;
    end
  endtask

  // One game tick as seen from a button press issued just after the previous tick.
  task automatic model_step(input int i, input bit pj, input bit ps);
    bit req, wrap, hit;
    req = pj && m[i].running;
    if (ps && !m[i].running) begin
      model_reload(i);
      m[i].running = 1'b1;
    end
    if (!m[i].running) return;
    if (m[i].air == 0) begin
      if (req) begin m[i].air = 1; m[i].vel = 12; end
    end else if (m[i].air == 1) begin
      m[i].y   -= m[i].vel;
      m[i].vel -= 1;
      if (m[i].vel == 0) m[i].air = 2;
    end else begin
      m[i].vel += 1;
      if (m[i].y + m[i].vel >= 450) begin m[i].y = 450; m[i].vel = 0; m[i].air = 0; end
      else m[i].y += m[i].vel;
    end
    wrap = (m[i].x <= 52);
    m[i].x = wrap ? sx[i] : m[i].x - 2;
    hit = (m[i].x > hxl[i]) && (m[i].x < hxr[i]) && (m[i].y > hy[i]);
    if (hit) begin
      m[i].running = 1'b0;
      m[i].over    = 1'b1;
    end else if (wrap) begin
      if (m[i].score < 65535) m[i].score += 1;
      m[i].ramp += 1;
      if (m[i].ramp == 4) begin
        m[i].ramp = 0;
        m[i].spd  = (m[i].spd - 10000 < 50000) ? 50000 : m[i].spd - 10000;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("d%0d.dino_y", i), 32'(dy[i]), 32'(m[i].y));
      chk($sformatf("d%0d.blk_x", i),  32'(bx[i]), 32'(m[i].x));
      chk($sformatf("d%0d.spd", i),    32'(sv[i]), 32'(m[i].spd));
      chk($sformatf("d%0d.isover", i), 32'(ov[i]), 32'(m[i].over));
      chk($sformatf("d%0d.score", i),  32'(sc[i]), 32'(m[i].score));
    end
  endtask

  // Entered on the falling edge just after a tick edge; leaves on the falling edge after the next tick.
  task automatic step(input bit pj, input bit ps);
    btn_jump  = pj;
    btn_start = ps;
    @(negedge clk);
    btn_jump  = 1'b0;
    btn_start = 1'b0;
    repeat (3) @(negedge clk);
    step_no++;
    for (int i = 0; i < 3; i++) model_step(i, pj, ps);
    check_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout step=%0d", step_no);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check_all();

    // Idle for 100 clocks; jump presses must be ignored.
    for (int k = 0; k < 25; k++) step(k[0], 1'b0);
    chk("idle.dino_y", 32'(dy[0]), 32'd450);
    chk("idle.blk_x",  32'(bx[0]), 32'd750);
    chk("idle.spd",    32'(sv[0]), 32'd200000);

    // Start and run without jumping until d0 collides.
    step(1'b0, 1'b1);
    for (int k = 0; k < 400 && !m[0].over; k++) step(1'b0, 1'b0);
    chk("run.d0_over",  32'(ov[0]), 32'd1);
    chk("run.d0_score", 32'(sc[0]), 32'd0);
    chk("run.d0_blk_x", 32'(bx[0]), 32'd324);
    chk("wraphit.d2_over",  32'(ov[2]), 32'd1);
    chk("wraphit.d2_score", 32'(sc[2]), 32'd0);
    chk("wraphit.d2_blk_x", 32'(bx[2]), 32'd60);

    // OVER freezes everything even with jump presses.
    for (int k = 0; k < 10; k++) step(k[0], 1'b0);
    chk("frozen.d0_blk_x", 32'(bx[0]), 32'd324);

    // Restart, then a full jump with a second press in mid-air.
    step(1'b0, 1'b1);
    chk("restart.d0_over",   32'(ov[0]), 32'd0);
    chk("restart.d0_blk_x",  32'(bx[0]), 32'd748);
    repeat (4) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0);
    chk("jump.peak", 32'(dy[0]), 32'd372);
    repeat (12) step(1'b0, 1'b0);
    chk("jump.landed", 32'(dy[0]), 32'd450);
    step(1'b0, 1'b0);
    chk("jump.stays", 32'(dy[0]), 32'd450);

    // Asynchronous reset in the middle of a rise.
    step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    chk("rise.mid_y", 32'(dy[0]), 32'd417);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) step(1'b1, 1'b0);
    chk("postrst.blk_x", 32'(bx[0]), 32'd750);

    // Speed ramp and floor on the short track.
    step(1'b0, 1'b1);
    repeat (19) step(1'b0, 1'b0);
    chk("ramp.score4", 32'(sc[1]), 32'd4);
    chk("ramp.spd4",   32'(sv[1]), 32'd190000);
    repeat (280) step(1'b0, 1'b0);
    chk("ramp.spd60",  32'(sv[1]), 32'd50000);
    repeat (20) step(1'b0, 1'b0);
    chk("ramp.floor",  32'(sv[1]), 32'd50000);
    chk("ramp.score64", 32'(sc[1]), 32'd64);

    // Random button traffic against the model.
    for (int k = 0; k < 300; k++) step(($urandom % 4) == 0, ($urandom % 16) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
